// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and the
// combinational instruction memory (slave).
interface fetch_stage_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handles boot/interrupt vectoring,
// assembles one- and two-byte instructions and loads the IF/ID register.
module fetch_stage #(
    parameter int         ADDR_W  = 8,
    parameter int         DATA_W  = 8,
    parameter logic [3:0] IMM_OPC = 4'hC
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              pc_en,
    input  logic              if_id_en,
    input  logic              flush,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              intr,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0] if_id_pc1,
    output logic              if_id_valid,
    output logic              int_ack,
    output logic [ADDR_W-1:0] int_ret_pc
);
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_IMM,
        ST_INTR
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc1;
        logic              valid;
    } if_id_t;

    localparam logic [ADDR_W-1:0] BOOT_VEC = '0;
    localparam logic [ADDR_W-1:0] INTR_VEC = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pend_q, pend_d;
    logic              int_ack_q, int_ack_d;
    logic [ADDR_W-1:0] int_ret_pc_q, int_ret_pc_d;
    if_id_t            if_id_q, if_id_d;
    if_id_t            fetched;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_imm_opc;

    // PC arithmetic wraps naturally at 2^ADDR_W.
    assign pc_inc     = pc_q + INTR_VEC;
    assign is_imm_opc = (imem.imem_data[7:4] == IMM_OPC);

    always_comb begin
        case (state_q)
            ST_BOOT: imem.imem_addr = BOOT_VEC;
            ST_INTR: imem.imem_addr = INTR_VEC;
            default: imem.imem_addr = pc_q;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise
        // paths that skip an assignment would infer latches.
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        pend_d       = pend_q | intr;
        int_ack_d    = 1'b0;
        int_ret_pc_d = int_ret_pc_q;
        fetched      = '0;

        if (br_taken) begin
            pc_d    = br_target;
            state_d = ST_RUN;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    pc_d    = ADDR_W'(imem.imem_data);
                    state_d = ST_RUN;
                end
                ST_RUN: if (pc_en) begin
                    if (pend_q || intr) begin
                        // Interrupts are only taken between whole instructions.
                        state_d      = ST_INTR;
                        int_ack_d    = 1'b1;
                        int_ret_pc_d = pc_q;
                        pend_d       = 1'b0;
                    end else if (is_imm_opc) begin
                        hold_d  = imem.imem_data;
                        pc_d    = pc_inc;
                        state_d = ST_IMM;
                    end else begin
                        fetched = '{instr: imem.imem_data, imm: '0, pc1: pc_inc, valid: 1'b1};
                        pc_d    = pc_inc;
                    end
                end
                ST_IMM: if (pc_en) begin
                    fetched = '{instr: hold_q, imm: imem.imem_data, pc1: pc_inc, valid: 1'b1};
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
                ST_INTR: if (pc_en) begin
                    pc_d    = ADDR_W'(imem.imem_data);
                    state_d = ST_RUN;
                end
                default: state_d = ST_BOOT;
            endcase
        end

        if (flush)         if_id_d = '0;
        else if (if_id_en) if_id_d = fetched;
        else               if_id_d = if_id_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= '0;
            hold_q       <= '0;
            pend_q       <= 1'b0;
            int_ack_q    <= 1'b0;
            int_ret_pc_q <= '0;
            if_id_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            int_ack_q    <= int_ack_d;
            int_ret_pc_q <= int_ret_pc_d;
            if_id_q      <= if_id_d;
        end
    end

    assign if_id_instr = if_id_q.instr;
    assign if_id_imm   = if_id_q.imm;
    assign if_id_pc1   = if_id_q.pc1;
    assign if_id_valid = if_id_q.valid;
    assign int_ack     = int_ack_q;
    assign int_ret_pc  = int_ret_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: instruction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_fetch_stage;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_en, if_id_en, flush, br_taken, intr;
    logic [AW-1:0] br_target;
    logic [DW-1:0] if_id_instr, if_id_imm;
    logic [AW-1:0] if_id_pc1, int_ret_pc;
    logic          if_id_valid, int_ack;
    logic [DW-1:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.imem_data = mem[bus.imem_addr];

    fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .IMM_OPC(4'hC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .intr       (intr),
        .if_id_instr(if_id_instr),
        .if_id_imm  (if_id_imm),
        .if_id_pc1  (if_id_pc1),
        .if_id_valid(if_id_valid),
        .int_ack    (int_ack),
        .int_ret_pc (int_ret_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which instruction is being fetched, not how.
    typedef struct packed {
        logic [7:0] pc;
        logic       booting;
        logic       vectoring;
        logic       mid_instr;
        logic [7:0] opcode;
        logic       pending;
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] pc1;
        logic       valid;
        logic       ack;
        logic [7:0] ret;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t n = '0;
        n.booting = 1'b1;
        return n;
    endfunction

    function automatic logic [7:0] fetch_addr(model_t s);
        if (s.booting)   return 8'h00;
        if (s.vectoring) return 8'h01;
        return s.pc;
    endfunction

    function automatic model_t model_next(model_t s, logic [7:0] b);
        model_t     n = s;
        logic [7:0] instr = 8'h00;
        logic [7:0] imm   = 8'h00;
        logic [7:0] pc1   = 8'h00;
        logic       valid = 1'b0;
        n.ack     = 1'b0;
        n.pending = s.pending | intr;
        if (br_taken) begin
            n.pc = br_target; n.booting = 1'b0; n.vectoring = 1'b0; n.mid_instr = 1'b0;
        end else if (s.booting) begin
            n.pc = b; n.booting = 1'b0;
        end else if (pc_en) begin
            if (s.vectoring) begin
                n.pc = b; n.vectoring = 1'b0;
            end else if (s.mid_instr) begin
                instr = s.opcode; imm = b; pc1 = s.pc + 8'd1; valid = 1'b1;
                n.pc = s.pc + 8'd1; n.mid_instr = 1'b0;
            end else if (n.pending) begin
                n.ack = 1'b1; n.ret = s.pc; n.vectoring = 1'b1; n.pending = 1'b0;
            end else if (b[7:4] == 4'hC) begin
                n.opcode = b; n.mid_instr = 1'b1; n.pc = s.pc + 8'd1;
            end else begin
                instr = b; pc1 = s.pc + 8'd1; valid = 1'b1; n.pc = s.pc + 8'd1;
            end
        end
        if (flush)         {n.instr, n.imm, n.pc1, n.valid} = '0;
        else if (if_id_en) {n.instr, n.imm, n.pc1, n.valid} = {instr, imm, pc1, valid};
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, mem[fetch_addr(m)]);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model imem_addr", bus.imem_addr, fetch_addr(m));
            check("model if_id", {if_id_instr, if_id_imm, if_id_pc1, if_id_valid},
                  {m.instr, m.imm, m.pc1, m.valid});
            check("model int_ack", int_ack, m.ack);
            check("model int_ret_pc", int_ret_pc, m.ret);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_state(input string name, input logic [7:0] addr, input logic [7:0] instr,
                             input logic [7:0] imm, input logic [7:0] pc1, input logic valid);
        check({name, " addr"}, bus.imem_addr, addr);
        check({name, " if_id"}, {if_id_instr, if_id_imm, if_id_pc1, if_id_valid},
              {instr, imm, pc1, valid});
    endtask

    task automatic idle_inputs();
        pc_en = 1'b1; if_id_en = 1'b1; flush = 1'b0;
        br_taken = 1'b0; br_target = '0; intr = 1'b0;
    endtask

    task automatic start_reset();
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        // Program A: boot, one-/two-byte, stall in IMM, branch in IMM, reset mid-IMM.
        start_reset();
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
        mem[8'h10] = 8'h01; mem[8'h11] = 8'hC2; mem[8'h12] = 8'h5A;
        mem[8'h13] = 8'hC3; mem[8'h14] = 8'h77; mem[8'h15] = 8'h02;
        mem[8'h16] = 8'hC4; mem[8'h17] = 8'h99;
        mem[8'h40] = 8'h06; mem[8'h41] = 8'hC7;
        tick(); tick();
        exp_state("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        check("reset int_ack", int_ack, 1'b0);
        check("reset int_ret_pc", int_ret_pc, 8'h00);
        rst_n = 1'b1;
        tick(); exp_state("boot e1", 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); exp_state("boot e2", 8'h11, 8'h01, 8'h00, 8'h11, 1'b1);
        tick(); exp_state("2byte opc", 8'h12, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); exp_state("2byte imm", 8'h13, 8'hC2, 8'h5A, 8'h13, 1'b1);
        tick(); exp_state("stall opc", 8'h14, 8'h00, 8'h00, 8'h00, 1'b0);
        pc_en = 1'b0; if_id_en = 1'b0;
        tick(); exp_state("stall 1", 8'h14, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); exp_state("stall 2", 8'h14, 8'h00, 8'h00, 8'h00, 1'b0);
        pc_en = 1'b1; if_id_en = 1'b1;
        tick(); exp_state("stall done", 8'h15, 8'hC3, 8'h77, 8'h15, 1'b1);
        tick(); exp_state("1byte 02", 8'h16, 8'h02, 8'h00, 8'h16, 1'b1);
        tick(); exp_state("br opc", 8'h17, 8'h00, 8'h00, 8'h00, 1'b0);
        br_taken = 1'b1; flush = 1'b1; br_target = 8'h40;
        tick(); exp_state("br in imm", 8'h40, 8'h00, 8'h00, 8'h00, 1'b0);
        idle_inputs();
        tick(); exp_state("br target", 8'h41, 8'h06, 8'h00, 8'h41, 1'b1);
        if_id_en = 1'b0;
        tick(); exp_state("hold ifid", 8'h42, 8'h06, 8'h00, 8'h41, 1'b1);
        #2 rst_n = 1'b0;
        #1 exp_state("rst mid imm", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        // Program B: interrupt in RUN, return by branch, interrupt deferred past IMM.
        start_reset();
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h80;
        mem[8'h20] = 8'h03; mem[8'h21] = 8'h04; mem[8'h22] = 8'hC5;
        mem[8'h23] = 8'h11; mem[8'h24] = 8'h07;
        mem[8'h80] = 8'h08; mem[8'h81] = 8'h09;
        tick(); rst_n = 1'b1;
        tick(); tick();
        tick(); exp_state("pre intr", 8'h22, 8'h04, 8'h00, 8'h22, 1'b1);
        intr = 1'b1;
        tick(); exp_state("intr take", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        check("intr ack", int_ack, 1'b1);
        check("intr ret", int_ret_pc, 8'h22);
        intr = 1'b0;
        tick(); check("vector pc", bus.imem_addr, 8'h80);
        check("ack one cycle", int_ack, 1'b0);
        tick(); exp_state("isr instr", 8'h81, 8'h08, 8'h00, 8'h81, 1'b1);
        br_taken = 1'b1; flush = 1'b1; br_target = 8'h22;
        tick(); exp_state("return", 8'h22, 8'h00, 8'h00, 8'h00, 1'b0);
        idle_inputs();
        tick(); exp_state("ret opc", 8'h23, 8'h00, 8'h00, 8'h00, 1'b0);
        intr = 1'b1;
        tick(); exp_state("defer imm", 8'h24, 8'hC5, 8'h11, 8'h24, 1'b1);
        check("deferred ack", int_ack, 1'b0);
        intr = 1'b0;
        tick(); check("late ack", int_ack, 1'b1);
        check("late ret", int_ret_pc, 8'h24);
        check("late addr", bus.imem_addr, 8'h01);
        #2 rst_n = 1'b0;
        #1 check("rst mid intr ack", int_ack, 1'b0);
        check("rst mid intr ret", int_ret_pc, 8'h00);
        check("rst mid intr addr", bus.imem_addr, 8'h00);

        // Program C: two-byte instruction across the 0xFF->0x00 wrap, flush over if_id_en=0.
        start_reset();
        mem[8'h00] = 8'hFE; mem[8'h01] = 8'h0B;
        mem[8'hFE] = 8'h0A; mem[8'hFF] = 8'hC6;
        tick(); rst_n = 1'b1;
        tick(); exp_state("wrap boot", 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); exp_state("wrap 0A", 8'hFF, 8'h0A, 8'h00, 8'hFF, 1'b1);
        tick(); exp_state("wrap opc", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); exp_state("wrap imm", 8'h01, 8'hC6, 8'hFE, 8'h01, 1'b1);
        flush = 1'b1; if_id_en = 1'b0; pc_en = 1'b0;
        tick(); exp_state("flush wins", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        idle_inputs();
        tick(); exp_state("after flush", 8'h02, 8'h0B, 8'h00, 8'h02, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core: owns the program counter, drives the instruction-memory address, assembles one- and two-byte instructions and loads the IF/ID pipeline register consumed by decode. It sits directly upstream of decode and is steered by the hazard unit's `pc_en`, `if_id_en` and `flush` outputs plus the EX-stage branch resolution. It also handles the boot vector (M[0]) and the interrupt vector (M[1]).

## Interface
- `ADDR_W`, default 8: PC and memory address width.
- `DATA_W`, default 8: instruction byte width.
- `IMM_OPC`, default 4'hC: value of `instr[7:4]` that marks a two-byte instruction (opcode byte followed by an immediate byte).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  ADDR_W  instruction-memory address; memory read is combinational, so data is valid in the same cycle.
- `imem_data`  in  DATA_W  instruction-memory read data.
- `pc_en`  in  1  from hazard unit; 0 freezes PC and FSM.
- `if_id_en`  in  1  from hazard unit; 0 freezes the IF/ID register.
- `flush`  in  1  from hazard unit; clears IF/ID to a bubble.
- `br_taken`  in  1  branch resolved taken in EX.
- `br_target`  in  ADDR_W  branch destination.
- `intr`  in  1  external interrupt request, level or pulse.
- `if_id_instr`  out  DATA_W  opcode byte.
- `if_id_imm`  out  DATA_W  immediate byte; 0 for one-byte instructions.
- `if_id_pc1`  out  ADDR_W  address following the instruction, used as the CALL return address.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.
- `int_ack`  out  1  one-cycle pulse when an interrupt is taken.
- `int_ret_pc`  out  ADDR_W  PC to resume after the interrupt; valid while `int_ack` = 1.

## Operation
- States: BOOT, RUN, IMM, INTR.
- `imem_addr` is 0 in BOOT, 1 in INTR, and PC otherwise.
- BOOT: PC <= `imem_data`, then go to RUN. IF/ID holds a bubble. Not affected by `pc_en`.
- RUN with `pc_en` = 1, one-byte instruction: IF/ID <= {instr = data, imm = 0, pc1 = PC+1, valid = 1}. PC <= PC+1.
- RUN with `pc_en` = 1, `data[7:4]` == `IMM_OPC`: save the opcode in a hold register, PC <= PC+1, go to IMM. IF/ID receives a bubble this cycle.
- IMM with `pc_en` = 1: IF/ID <= {instr = hold, imm = data, pc1 = PC+1, valid = 1}. PC <= PC+1, then go to RUN.
- Interrupt pending flag: set by `intr`, cleared when taken.
  - Taken only in RUN, with `pc_en` = 1 and `br_taken` = 0, so it never splits a two-byte instruction.
  - Taking it: `int_ack` = 1, `int_ret_pc` = PC, then go to INTR. IF/ID receives a bubble.
  - INTR: PC <= `imem_data`, then go to RUN.
- Priority, highest first:
  1. `rst_n`
  2. `br_taken`: PC <= `br_target`, state <= RUN, hold register discarded. Also wins over a stall and over IMM/INTR.
  3. `flush`: `if_id_valid` <= 0, instr/imm/pc1 <= 0. Overrides `if_id_en` = 0.
  4. `pc_en` = 0: PC, state and hold register keep their values.
  5. `if_id_en` = 0: IF/ID keeps its value.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00, including inside a two-byte instruction.

## Timing
- Reset values: PC = 0, state = BOOT, all IF/ID fields = 0, `int_ack` = 0, `int_ret_pc` = 0, pending flag = 0.
- After `rst_n` deasserts: the first edge loads PC from M[0]. The first valid IF/ID appears on the second edge.
- A one-byte instruction reaches IF/ID on the edge after its address is driven. A two-byte instruction takes 2 cycles, with a bubble ahead of it.
- `br_taken` on edge N: `imem_addr` = `br_target` in cycle N+1, and the target instruction is in IF/ID at edge N+1.
- `int_ack` is high for exactly one cycle. The vector PC is loaded one edge later.
- Asserting `rst_n` mid-IMM or mid-INTR clears everything immediately; no partial instruction is left visible.

## Test plan
- Boot: M[0]=0x10, M[0x10]=0x01 -> edge 1 PC=0x10; edge 2 IF/ID={0x01, 0, 0x11, valid}.
- Two-byte: M[0x10]=0xC2, M[0x11]=0x5A -> bubble, then IF/ID={0xC2, 0x5A, 0x12, valid}, PC=0x12.
- Load-use stall: `pc_en` = `if_id_en` = 0 for 2 cycles during IMM -> PC, state and IF/ID unchanged; completes correctly after release.
- Branch in IMM: `br_taken` = 1, `flush` = 1, `br_target` = 0x40 -> IF/ID bubble, PC=0x40, state RUN, opcode discarded.
- Interrupt: `intr` pulse at PC=0x22 in RUN, M[1]=0x80 -> `int_ack` = 1 with `int_ret_pc` = 0x22; next edge PC=0x80. A second `intr` raised during IMM is deferred until RUN.
- Wrap: PC=0xFF holding a two-byte opcode -> immediate read from 0x00, pc1=0x01.
